// File: rtl/seq_pkg.sv
// Shared types for the step sequencer: FSM state encoding and step index width.
package seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} seq_state_t;
  localparam int STEP_W = 4;
endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider that emits a registered one-cycle tick every DIV enabled cycles.
module tick_prescaler #(
  parameter int DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // clr wins over en so an abort or sequence end also kills a pending tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + CW'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end
endmodule

// File: rtl/step_sequencer.sv
// Drives the seconds timer with a tick enable and step index; counts its done pulses
// and flags the end of a full sequence.
module step_sequencer
  import seq_pkg::*;
#(
  parameter int CLK_HZ    = 25_000_000,
  parameter int TICK_HZ   = 1,
  parameter int NUM_STEPS = 10,
  parameter int LOOP      = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic              abort,
  input  logic              timer_done,
  output logic              tick,
  output logic [STEP_W-1:0] step,
  output logic              running,
  output logic              seq_done
);
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  seq_state_t state, nxt;
  logic active, last_done, end_seq, clr, en;

  assign active    = (state != IDLE);
  assign last_done = active && timer_done && (step == LAST_STEP);
  assign end_seq   = last_done && (LOOP == 0);
  assign clr       = abort || !active || end_seq;
  assign en        = (state == RUN);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start && !abort) nxt = RUN;
      RUN:     if (abort || end_seq) nxt = IDLE;
               else if (pause)      nxt = PAUSE;
      PAUSE:   if (abort || end_seq) nxt = IDLE;
               else if (!pause)     nxt = RUN;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      step     <= '0;
      running  <= 1'b0;
      seq_done <= 1'b0;
    end else begin
      state    <= nxt;
      running  <= (nxt != IDLE);
      seq_done <= last_done && !abort;
      // done is taken in PAUSE too: it trails the tick by two cycles
      if (abort || !active)
        step <= '0;
      else if (timer_done)
        step <= last_done ? '0 : step + STEP_W'(1);
    end
  end

  tick_prescaler #(.DIV(TICK_DIV)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (en),
    .tick (tick)
  );
endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench: two sequencers (LOOP=0 and LOOP=1) share stimulus; each drives a
// behavioural timer that pulses done two cycles after every second tick.
module tb_step_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, pause = 1'b0, abort = 1'b0;
  logic tick_a, run_a, sd_a, tick_l, run_l, sd_l;
  logic [3:0] step_a, step_l;
  logic [1:0] tk, d1, tdone, tpar;
  int n_chk = 0, n_err = 0, t = 0;

  always #5 clk = ~clk;

  step_sequencer #(.CLK_HZ(8), .TICK_HZ(1), .NUM_STEPS(3), .LOOP(0)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .timer_done(tdone[0]), .tick(tick_a), .step(step_a), .running(run_a), .seq_done(sd_a));

  step_sequencer #(.CLK_HZ(8), .TICK_HZ(1), .NUM_STEPS(3), .LOOP(1)) dut_l (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .timer_done(tdone[1]), .tick(tick_l), .step(step_l), .running(run_l), .seq_done(sd_l));

  assign tk = {tick_l, tick_a};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      d1 <= '0; tdone <= '0; tpar <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        d1[k]    <= tk[k] && tpar[k];
        tdone[k] <= d1[k];
        if (tk[k]) tpar[k] <= ~tpar[k];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk); #1; t++;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 0; pause = 0; abort = 0;
    adv(); adv();
    rst = 1'b0;
    adv();
  endtask

  // start sampled on the next edge; that edge is t=0
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
  endtask

  initial begin
    // reset hold with start toggling
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start = ~start;
      adv();
      chk("rst_out", {tick_a, run_a, sd_a, step_a}, 32'h0);
      chk("rst_st", dut.state, 32'h0);
    end
    start = 0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      adv();
      chk("idle_out", {tick_a, run_a, sd_a, step_a, tick_l, run_l}, 32'h0);
    end

    // normal run, both instances
    do_start();
    chk("run0", run_a, 1);
    for (int i = 1; i <= 70; i++) begin
      adv();
      chk("n_tick", tick_a, (t % 8 == 0 && t <= 48) ? 1 : 0);
      chk("n_step", step_a, t < 19 ? 0 : t < 35 ? 1 : t < 51 ? 2 : 0);
      chk("n_sd",   sd_a, t == 51 ? 1 : 0);
      chk("n_run",  run_a, t < 51 ? 1 : 0);
      chk("l_tick", tick_l, (t % 8 == 0) ? 1 : 0);
      chk("l_step", step_l, t < 19 ? 0 : t < 35 ? 1 : t < 51 ? 2 : t < 67 ? 0 : 1);
      chk("l_sd",   sd_l, t == 51 ? 1 : 0);
      chk("l_run",  run_l, 1);
    end

    // pause sampled at edges 12..29: count frozen at 4, next tick at 34
    do_reset();
    do_start();
    for (int i = 1; i <= 40; i++) begin
      if (t == 11) pause = 1'b1;
      if (t == 29) pause = 1'b0;
      adv();
      chk("p_tick", tick_a, (t == 8 || t == 34) ? 1 : 0);
      chk("p_run", run_a, 1);
      if (t == 20) chk("p_state", dut.state, 32'h2);
    end
    chk("p_step", step_a, 1);

    // done landing in PAUSE after the second tick still advances step
    do_reset();
    do_start();
    for (int i = 1; i <= 30; i++) begin
      if (t == 16) pause = 1'b1;
      adv();
      if (t == 18) chk("pd_step0", step_a, 0);
      if (t == 19) chk("pd_step1", step_a, 1);
      if (t > 16) chk("pd_tick", tick_a, 0);
    end
    pause = 1'b0;

    // abort mid-run at step 1
    do_reset();
    do_start();
    while (t < 20) adv();
    chk("a_pre", step_a, 1);
    abort = 1'b1;
    adv();
    abort = 1'b0;
    chk("a_step", step_a, 0);
    chk("a_run", run_a, 0);
    chk("a_state", dut.state, 32'h0);
    for (int i = 0; i < 40; i++) begin
      adv();
      chk("a_quiet", {tick_a, sd_a, run_a}, 32'h0);
    end

    // abort coinciding with the last done
    do_reset();
    do_start();
    while (t < 50) adv();
    chk("ad_done_in", tdone[0], 1);
    chk("ad_step", step_a, 2);
    abort = 1'b1;
    adv();
    abort = 1'b0;
    chk("ad_sd", sd_a, 0);
    chk("ad_out", {step_a, run_a}, 32'h0);
    adv();
    chk("ad_sd2", sd_a, 0);

    // start and abort together in IDLE
    do_reset();
    start = 1'b1; abort = 1'b1;
    adv();
    start = 1'b0; abort = 1'b0;
    chk("sa_run", run_a, 0);
    for (int i = 0; i < 10; i++) begin
      adv();
      chk("sa_quiet", {tick_a, run_a}, 32'h0);
    end

    // asynchronous reset mid-run
    do_reset();
    do_start();
    while (t < 20) adv();
    chk("ar_pre", {run_a, step_a}, 32'h11);
    #2 rst = 1'b1;
    #1;
    chk("ar_async", {run_a, step_a, run_l, step_l}, 32'h0);
    chk("ar_state", dut.state, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0d got=running exp=finished", t);
    $fatal(1, "timeout");
  end
endmodule
